hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//   Multi-cycle MIPS multiply/divide unit that feeds the HI/LO register pair
//   (the downstream Register instances). Accepts MULT/MULTU/DIV/DIVU in the EX
//   stage and computes iteratively: shift-add multiply, restoring divide.
//   hilo_write strobes the result into HI/LO. busy drives the hazard unit,
//   which stalls any MFHI/MFLO or new mul/div while an operation is in flight.
// PARAMETERS
//   N      32  operand width. Product and quotient/remainder are 2N bits split into HI/LO.
//   START  0   reset value of hi_out and lo_out.
// PORTS
//   clk           in   1   clock; every state change happens on posedge.
//   reset         in   1   synchronous reset, active-high.
//   start         in   1   request a new operation; sampled only in IDLE.
//   op            in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
//   operand_a     in   N   rs: multiplicand or dividend.
//   operand_b     in   N   rt: multiplier or divisor.
//   busy          out  1   1 from the cycle after start is accepted through the DONE cycle.
//   hilo_write    out  1   1-cycle pulse in the DONE cycle; write enable for the HI/LO Registers.
//   hi_out        out  N   product[2N-1:N] or remainder.
//   lo_out        out  N   product[N-1:0] or quotient.
//   div_by_zero   out  1   valid when hilo_write=1: divide op with operand_b==0.
// BEHAVIOUR
//   - Reset value of each output: busy=0, hilo_write=0, hi_out=START, lo_out=START,
//     div_by_zero=0. Internal state: FSM=IDLE, iteration counter=0.
//   - Reset asserted in any state aborts the operation at the next posedge.
//     No hilo_write is produced for an aborted operation.
//   - FSM states and transitions:
//       IDLE: start=1 -> latch op and operands, go to RUN.
//       RUN:  exactly N iterations, one per clock; counter counts 0..N-1,
//             then go to DONE.
//       DONE: one cycle, then back to IDLE.
//   - Latency: start sampled at edge t -> RUN during cycles t+1..t+N -> DONE in
//     cycle t+N+1. In DONE, hilo_write=1 and hi_out/lo_out already hold the new
//     result. Next start is accepted at the edge that ends DONE, so back-to-back
//     issue runs every N+1 cycles.
//   - start in RUN or DONE: ignored, not queued. op and operands are don't-care
//     outside an accepted start.
//   - hi_out/lo_out: registered. They update only on the edge entering DONE and
//     hold their value otherwise.
//   - Multiply: unsigned N x N -> 2N shift-add; no overflow possible.
//   - Divide: restoring, N-bit quotient into lo_out, N-bit remainder into hi_out.
//   - Divide by zero: still takes the full N+1 latency; result is lo_out=all ones,
//     hi_out=dividend (magnitude path), div_by_zero=1.
//   - div_by_zero is 0 for multiply ops. It holds its value until the next DONE.
// CONFIGURATION
//   MULDIV_SIGNED_EN defined:
//     - op[0]=1 is signed. Operands are converted to magnitudes and the unsigned
//       core runs on them.
//     - Product is negated when the operand signs differ.
//     - Quotient sign = sign(a) XOR sign(b); remainder takes the sign of a.
//     - Most-negative / -1: quotient=0x80000000 (2's-complement wrap), remainder=0.
//     - Divide by zero in signed mode: lo_out=all ones, hi_out=operand_a unchanged.
//   MULDIV_SIGNED_EN undefined:
//     - op[0] is ignored; all ops are unsigned. The sign/negate logic is not synthesised.
// TESTING
//   1. MULTU 0xFFFFFFFF*0xFFFFFFFF, start at t -> busy t+1..t+33; hilo_write only
//      at t+33; hi=0xFFFFFFFE, lo=0x00000001.
//   2. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002, div_by_zero=0. Then issue
//      start in the DONE cycle: the new op's hilo_write comes exactly 33 cycles later.
//   3. DIVU 5/0 -> lo=0xFFFFFFFF, hi=0x00000005, div_by_zero=1 at t+33.
//   4. MULT 0xFFFFFFFD*5:
//        - with MULDIV_SIGNED_EN: hi=0xFFFFFFFF, lo=0xFFFFFFF1;
//        - without it: hi=0x00000004, lo=0xFFFFFFF1.
//   5. DIV -7/2 (signed build) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//      DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//   6. Issue MULTU; pulse start in RUN cycle 5 (ignored); assert reset in RUN
//      cycle 10 -> next cycle busy=0, hi/lo=0, and no hilo_write within the next
//      40 cycles.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS multiply/divide unit feeding the HI/LO register pair.
// Shift-add multiply and restoring divide, one iteration per clock, N+1 cycle latency.
// Optional signed support (MULT/DIV) is compiled in with `define MULDIV_SIGNED_EN.
module hilo_muldiv_unit #(
    parameter int unsigned  N     = 32,
    parameter logic [N-1:0] START = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] operand_a,
    input  logic [N-1:0] operand_b,
    output logic         busy,
    output logic         hilo_write,
    output logic [N-1:0] hi_out,
    output logic [N-1:0] lo_out,
    output logic         div_by_zero
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           is_div_q, is_div_d;
    logic           dbz_pend_q, dbz_pend_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   b_q, b_d;
    logic           busy_q, busy_d;
    logic           hilo_write_q, hilo_write_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           dbz_q, dbz_d;

    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N-1:0]   div_diff;
    logic           div_ge;
    logic [N-1:0]   rem_step, quo_step;
    logic [2*N-1:0] prod;
    logic [N-1:0]   res_hi, res_lo;
    logic           accept;

`ifdef MULDIV_SIGNED_EN
    logic           neg_q, neg_d;
    logic           neg_rem_q, neg_rem_d;
    logic           a_neg, b_neg;

    // Signed ops run the unsigned core on operand magnitudes
    always_comb begin
        a_neg = op[0] & operand_a[N-1];
        b_neg = op[0] & operand_b[N-1];
        a_mag = a_neg ? -operand_a : operand_a;
        b_mag = b_neg ? -operand_b : operand_b;
    end
`else
    logic unused_op0;

    // Unsigned-only build: operands feed the core directly, op[0] is ignored
    assign a_mag      = operand_a;
    assign b_mag      = operand_b;
    assign unused_op0 = op[0];
`endif

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : {(N+1){1'b0}});
        div_shift = {rem_q, quo_q[N-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = N'(div_shift - {1'b0, b_q});
        if (is_div_q) begin
            rem_step = div_ge ? div_diff : div_shift[N-1:0];
            quo_step = {quo_q[N-2:0], div_ge};
        end else begin
            rem_step = mul_sum[N:1];
            quo_step = {mul_sum[0], quo_q[N-1:1]};
        end
    end

    // Final result from the last iteration, with sign fix-up when enabled
    always_comb begin
        prod   = {rem_step, quo_step};
        res_hi = rem_step;
        res_lo = quo_step;
        if (is_div_q) begin
`ifdef MULDIV_SIGNED_EN
            if (neg_rem_q) res_hi = -rem_step;
            if (neg_q)     res_lo = -quo_step;
`endif
        end else begin
`ifdef MULDIV_SIGNED_EN
            if (neg_q) prod = -prod;
`endif
            res_hi = prod[2*N-1:N];
            res_lo = prod[N-1:0];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_div_d     = is_div_q;
        dbz_pend_d   = dbz_pend_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        b_d          = b_q;
        hilo_write_d = 1'b0;
        hi_d         = hi_q;
        lo_d         = lo_q;
        dbz_d        = dbz_q;
`ifdef MULDIV_SIGNED_EN
        neg_d        = neg_q;
        neg_rem_d    = neg_rem_q;
`endif
        accept       = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept = start;
            end
            S_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d      = S_DONE;
                    cnt_d        = '0;
                    hilo_write_d = 1'b1;
                    hi_d         = res_hi;
                    lo_d         = res_lo;
                    dbz_d        = dbz_pend_q;
                end
            end
            S_DONE: begin
                // The edge ending DONE may already accept the next operation
                state_d = S_IDLE;
                accept  = start;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d    = S_RUN;
            cnt_d      = '0;
            is_div_d   = op[1];
            dbz_pend_d = op[1] & (operand_b == '0);
            rem_d      = '0;
            quo_d      = a_mag;
            b_d        = b_mag;
`ifdef MULDIV_SIGNED_EN
            // Divide by zero keeps quotient all ones; remainder sign fix-up restores operand_a
            neg_d      = (a_neg ^ b_neg) & ~(op[1] & (operand_b == '0));
            neg_rem_d  = a_neg & op[1];
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_div_q     <= 1'b0;
            dbz_pend_q   <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            b_q          <= '0;
            busy_q       <= 1'b0;
            hilo_write_q <= 1'b0;
            hi_q         <= START;
            lo_q         <= START;
            dbz_q        <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q        <= 1'b0;
            neg_rem_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_div_q     <= is_div_d;
            dbz_pend_q   <= dbz_pend_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            b_q          <= b_d;
            busy_q       <= busy_d;
            hilo_write_q <= hilo_write_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            dbz_q        <= dbz_d;
`ifdef MULDIV_SIGNED_EN
            neg_q        <= neg_d;
            neg_rem_q    <= neg_rem_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign hilo_write  = hilo_write_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed spec cases, back-to-back issue,
// reset abort and randomized operations against an arithmetic reference model.
module tb_hilo_muldiv_unit;

    localparam int unsigned N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] operand_a;
    logic [N-1:0] operand_b;
    logic         busy;
    logic         hilo_write;
    logic [N-1:0] hi_out;
    logic [N-1:0] lo_out;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    hilo_muldiv_unit #(.N(N), .START('0)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .hilo_write  (hilo_write),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain MIPS HI/LO arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        logic        sg;
        logic [63:0] p;
        sg = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sg = o[0];
`endif
        dz = 1'b0;
        if (!o[1]) begin
            if (sg) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            else    p = {32'b0, a} * {32'b0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
            dz = 1'b1;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                lo = $signed(a) / $signed(b);
                hi = $signed(a) % $signed(b);
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    function automatic logic [31:0] pick_val();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op at the current negedge and check cycle-accurate handshake and result.
    // chain=1 returns in the DONE cycle so the caller can issue back-to-back.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit chain, input bit noise);
        logic [31:0] eh, el;
        logic        ed;
        model(o, a, b, eh, el, ed);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        for (int k = 1; k <= int'(N) + 1; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy op=%0d cycle=%0d got=%b want=1", o, k, busy);
            end
            checks++;
            if (hilo_write !== 1'(k == int'(N) + 1)) begin
                errors++;
                $display("FAIL hilo_write op=%0d cycle=%0d got=%b want=%b", o, k, hilo_write, k == int'(N) + 1);
            end
            if (k == int'(N) + 1) begin
                checks++;
                if (hi_out !== eh) begin
                    errors++;
                    $display("FAIL hi op=%0d a=%h b=%h got=%h want=%h", o, a, b, hi_out, eh);
                end
                checks++;
                if (lo_out !== el) begin
                    errors++;
                    $display("FAIL lo op=%0d a=%h b=%h got=%h want=%h", o, a, b, lo_out, el);
                end
                checks++;
                if (div_by_zero !== ed) begin
                    errors++;
                    $display("FAIL div_by_zero op=%0d a=%h b=%h got=%b want=%b", o, a, b, div_by_zero, ed);
                end
            end
            if (k <= int'(N) && noise) begin
                start     = 1'($urandom_range(0, 1));
                op        = 2'($urandom_range(0, 3));
                operand_a = $urandom;
                operand_b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        if (!chain) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || hilo_write !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_done busy=%b hilo_write=%b want=0,0", busy, hilo_write);
            end
            checks++;
            if (hi_out !== eh || lo_out !== el || div_by_zero !== ed) begin
                errors++;
                $display("FAIL hold hi=%h lo=%h dz=%b want %h %h %b", hi_out, lo_out, div_by_zero, eh, el, ed);
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'd0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hilo_write !== 1'b0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b hw=%b dz=%b want 0", busy, hilo_write, div_by_zero);
        end
        checks++;
        if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("FAIL reset_hilo hi=%h lo=%h want 0", hi_out, lo_out);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hilo_write !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle busy=%b hw=%b want 0", busy, hilo_write);
        end
    endtask

    task automatic test_directed();
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        do_op(2'b00, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
        do_op(2'b10, 32'd3, 32'd7, 1'b0, 1'b0);
        do_op(2'b10, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    endtask

    task automatic test_signed_cases();
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
        do_op(2'b11, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op(2'b10, 32'd100, 32'd7, 1'b1, 1'b0);
        do_op(2'b00, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
        do_op(2'b10, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        do_op(2'b00, 32'd12345, 32'd678, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a, b;
            a = pick_val();
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_val();
            do_op(2'($urandom_range(0, 3)), a, b, (i != 29) && ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_abort();
        start     = 1'b1;
        op        = 2'b00;
        operand_a = 32'hFFFF_FFFF;
        operand_b = 32'h0000_0003;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || hilo_write !== 1'b0) begin
                errors++;
                $display("FAIL abort_run cycle=%0d busy=%b hw=%b want 1,0", k, busy, hilo_write);
            end
            start = (k == 5);
            reset = (k == 10);
        end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("FAIL abort_reset busy=%b hi=%h lo=%h want 0", busy, hi_out, lo_out);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (hilo_write !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet cycle=%0d hw=%b busy=%b want 0,0", k, hilo_write, busy);
            end
        end
        do_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_signed_cases();
        test_back_to_back();
        test_random();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
